// File: rtl/bp_be_mmu_cmd_arbiter_if.sv
// Command/response bundle between the two BE requesters, the arbiter and the MMU.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface bp_be_mmu_cmd_arbiter_if #(
    parameter int cmd_width_p  = 136,
    parameter int resp_width_p = 72
);
    logic [1:0]              cmd_v_i;
    logic [cmd_width_p-1:0]  cmd0_i;
    logic [cmd_width_p-1:0]  cmd1_i;
    logic [1:0]              cmd_ready_o;
    logic                    mmu_cmd_v_o;
    logic [cmd_width_p-1:0]  mmu_cmd_o;
    logic                    mmu_cmd_ready_i;
    logic                    mmu_resp_v_i;
    logic [resp_width_p-1:0] mmu_resp_i;
    logic                    mmu_resp_ready_o;
    logic [1:0]              resp_v_o;
    logic [resp_width_p-1:0] resp_o;
    logic [1:0]              resp_ready_i;
    logic                    flush_i;

    modport slave (
        input  cmd_v_i, cmd0_i, cmd1_i,
        output cmd_ready_o,
        output mmu_cmd_v_o, mmu_cmd_o,
        input  mmu_cmd_ready_i,
        input  mmu_resp_v_i, mmu_resp_i,
        output mmu_resp_ready_o,
        output resp_v_o, resp_o,
        input  resp_ready_i,
        input  flush_i
    );

    modport master (
        output cmd_v_i, cmd0_i, cmd1_i,
        input  cmd_ready_o,
        input  mmu_cmd_v_o, mmu_cmd_o,
        output mmu_cmd_ready_i,
        output mmu_resp_v_i, mmu_resp_i,
        input  mmu_resp_ready_o,
        input  resp_v_o, resp_o,
        output resp_ready_i,
        output flush_i
    );
endinterface

// File: rtl/bp_be_mmu_cmd_arbiter.sv
// Round-robin arbiter sharing the BE MMU channel between the memory stage and the
// auxiliary sequencer: one-entry issue slot, credit cap, in-order ID/kill FIFO.
module bp_be_mmu_cmd_arbiter #(
    parameter int cmd_width_p       = 136,
    parameter int resp_width_p      = 72,
    parameter int max_outstanding_p = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    bp_be_mmu_cmd_arbiter_if.slave io
);
    localparam int unsigned PtrW = $clog2(max_outstanding_p);
    localparam int unsigned CntW = $clog2(max_outstanding_p + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(max_outstanding_p);

    typedef enum logic {
        RR_REQ0 = 1'b0,
        RR_REQ1 = 1'b1
    } rr_e;

    rr_e                     rr_q, rr_d;
    logic                    slot_v_q, slot_v_d;
    logic [cmd_width_p-1:0]  slot_cmd_q, slot_cmd_d;
    logic                    slot_id_q, slot_id_d;
    logic [CntW-1:0]         count_q, count_d;
    logic [PtrW:0]           rd_ptr_q, wr_ptr_q;
    logic [max_outstanding_p-1:0] fifo_id_q, fifo_kill_q;

    logic                    mmu_cmd_v;
    logic                    issue;
    logic                    fifo_empty;
    logic                    head_id;
    logic                    head_kill;
    logic                    resp_ready;
    logic [1:0]              resp_v;
    logic                    pop;
    logic                    can_accept;
    logic                    sel;
    logic [1:0]              cmd_ready;
    logic                    grant;
    logic                    slot_clear;
    logic [resp_width_p-1:0] resp_data;

    // Outputs are gated by reset so nothing stale leaks out in the reset cycle itself.
    always_comb begin
        mmu_cmd_v  = slot_v_q & reset_n_i;
        issue      = mmu_cmd_v & io.mmu_cmd_ready_i;
        fifo_empty = (rd_ptr_q == wr_ptr_q);
        head_id    = fifo_id_q[rd_ptr_q[PtrW-1:0]];
        head_kill  = fifo_kill_q[rd_ptr_q[PtrW-1:0]];

        resp_ready = reset_n_i & ~fifo_empty & (head_kill | io.resp_ready_i[head_id]);
        resp_v     = '0;
        if (reset_n_i && !fifo_empty && !head_kill && io.mmu_resp_v_i) begin
            resp_v[head_id] = 1'b1;
        end
        pop = io.mmu_resp_v_i & resp_ready;

        can_accept = reset_n_i & ~io.flush_i & ((count_q < MaxCnt) | pop)
                   & (~slot_v_q | issue);

        unique case (io.cmd_v_i)
            2'b01:   sel = 1'b0;
            2'b10:   sel = 1'b1;
            default: sel = rr_q;
        endcase
        cmd_ready      = '0;
        cmd_ready[sel] = can_accept;
        grant          = can_accept & io.cmd_v_i[sel];
        slot_clear     = io.flush_i & slot_v_q & ~issue;
    end

    always_comb begin
        rr_d       = rr_q;
        slot_v_d   = slot_v_q;
        slot_cmd_d = slot_cmd_q;
        slot_id_d  = slot_id_q;
        if (grant) begin
            slot_v_d   = 1'b1;
            slot_cmd_d = sel ? io.cmd1_i : io.cmd0_i;
            slot_id_d  = sel;
            rr_d       = sel ? RR_REQ0 : RR_REQ1;
        end else if (issue || io.flush_i) begin
            slot_v_d = 1'b0;
        end
        count_d = count_q + CntW'(grant) - CntW'(pop) - CntW'(slot_clear);
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            rr_q        <= RR_REQ0;
            slot_v_q    <= 1'b0;
            slot_cmd_q  <= '0;
            slot_id_q   <= 1'b0;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            fifo_id_q   <= '0;
            fifo_kill_q <= '0;
        end else begin
            rr_q       <= rr_d;
            slot_v_q   <= slot_v_d;
            slot_cmd_q <= slot_cmd_d;
            slot_id_q  <= slot_id_d;
            count_q    <= count_d;
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            // Flush marks every entry killed; a popping head is already routed this
            // cycle, and the push below overrides its own entry with kill=flush.
            if (io.flush_i) begin
                fifo_kill_q <= '1;
            end
            if (issue) begin
                fifo_id_q[wr_ptr_q[PtrW-1:0]]   <= slot_id_q;
                fifo_kill_q[wr_ptr_q[PtrW-1:0]] <= io.flush_i;
                wr_ptr_q                        <= wr_ptr_q + 1'b1;
            end
        end
    end

    assign resp_data           = io.mmu_resp_i;
    assign io.resp_o           = resp_data;
    assign io.resp_v_o         = resp_v;
    assign io.mmu_resp_ready_o = resp_ready;
    assign io.cmd_ready_o      = cmd_ready;
    assign io.mmu_cmd_v_o      = mmu_cmd_v;
    assign io.mmu_cmd_o        = slot_cmd_q;
endmodule

// File: tb/tb_bp_be_mmu_cmd_arbiter.sv
// Randomized and directed bench for bp_be_mmu_cmd_arbiter against a queue-based
// model of the issue slot and in-flight response order.
module tb_bp_be_mmu_cmd_arbiter;
    localparam int CW  = 136;
    localparam int RW  = 72;
    localparam int MAX = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bp_be_mmu_cmd_arbiter_if #(.cmd_width_p(CW), .resp_width_p(RW)) bus ();

    bp_be_mmu_cmd_arbiter #(
        .cmd_width_p(CW),
        .resp_width_p(RW),
        .max_outstanding_p(MAX)
    ) u_dut (
        .clk_i(clk),
        .reset_n_i(rst_n),
        .io(bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: pending slot plus in-order queue of {originator, killed}.
    bit          m_slot_v = 0;
    logic [CW-1:0] m_slot_cmd = '0;
    int          m_slot_id = 0;
    int          q_id[$];
    bit          q_kill[$];
    int          m_rr = 0;

    task automatic check_eq(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CW-1:0] rand_cmd();
        logic [CW-1:0] c;
        for (int i = 0; i < CW; i++) c[i] = 1'($urandom_range(0, 1));
        return c;
    endfunction

    function automatic logic [RW-1:0] rand_resp();
        logic [RW-1:0] r;
        for (int i = 0; i < RW; i++) r[i] = 1'($urandom_range(0, 1));
        return r;
    endfunction

    // One clock cycle: entered 1 time unit after a posedge, leaves at the same point.
    task automatic step(input bit rst, input logic [1:0] cv, input bit mr, input bit rv,
                        input logic [1:0] rrdy, input bit fl, output logic [1:0] rdy_obs);
        logic [CW-1:0] c0, c1;
        int  cnt, hid, g;
        bit  has_head, hk, e_rr, pop, issue, can, granted;
        logic [1:0] e_rv, e_rdy;
        c0 = rand_cmd();
        c1 = rand_cmd();
        rst_n               = rst;
        bus.cmd_v_i         = cv;
        bus.cmd0_i          = c0;
        bus.cmd1_i          = c1;
        bus.mmu_cmd_ready_i = mr;
        bus.mmu_resp_v_i    = rv;
        bus.mmu_resp_i      = rand_resp();
        bus.resp_ready_i    = rrdy;
        bus.flush_i         = fl;
        #4;
        rdy_obs  = bus.cmd_ready_o;
        cnt      = int'(m_slot_v) + q_id.size();
        has_head = q_id.size() > 0;
        hid      = has_head ? q_id[0] : 0;
        hk       = has_head ? q_kill[0] : 1'b0;
        e_rr     = rst && has_head && (hk || rrdy[hid]);
        e_rv     = (rst && has_head && !hk && rv) ? (2'b01 << hid) : 2'b00;
        pop      = rv && e_rr;
        issue    = rst && m_slot_v && mr;
        can      = rst && !fl && (cnt < MAX || pop) && (!m_slot_v || issue);
        g        = (cv == 2'b11) ? m_rr : ((cv == 2'b10) ? 1 : 0);
        e_rdy    = can ? (2'b01 << g) : 2'b00;
        granted  = can && (cv != 2'b00);

        check_eq("mmu_cmd_v", CW'(bus.mmu_cmd_v_o), CW'(rst && m_slot_v));
        if (rst && m_slot_v) check_eq("mmu_cmd", bus.mmu_cmd_o, m_slot_cmd);
        check_eq("mmu_resp_ready", CW'(bus.mmu_resp_ready_o), CW'(e_rr));
        check_eq("resp_v", CW'(bus.resp_v_o), CW'(e_rv));
        if (e_rv != 2'b00) check_eq("resp_data", CW'(bus.resp_o), CW'(bus.mmu_resp_i));
        if (!rst || cv != 2'b00) check_eq("cmd_ready", CW'(bus.cmd_ready_o), CW'(e_rdy));

        if (!rst) begin
            m_slot_v = 0;
            q_id.delete();
            q_kill.delete();
            m_rr = 0;
        end else begin
            if (pop) begin
                void'(q_id.pop_front());
                void'(q_kill.pop_front());
            end
            if (fl) foreach (q_kill[i]) q_kill[i] = 1'b1;
            if (issue) begin
                q_id.push_back(m_slot_id);
                q_kill.push_back(fl);
            end
            if (granted) begin
                m_slot_v   = 1;
                m_slot_cmd = (g == 1) ? c1 : c0;
                m_slot_id  = g;
                m_rr       = 1 - g;
            end else if (issue || fl) begin
                m_slot_v = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    logic [1:0] rdy;
    int accepts;

    initial begin
        rst_n = 1'b0;
        bus.cmd_v_i = '0; bus.cmd0_i = '0; bus.cmd1_i = '0;
        bus.mmu_cmd_ready_i = 1'b0; bus.mmu_resp_v_i = 1'b0; bus.mmu_resp_i = '0;
        bus.resp_ready_i = '0; bus.flush_i = 1'b0;
        @(posedge clk);
        #1;
        repeat (2) step(0, 2'b11, 1, 1, 2'b11, 0, rdy);

        // Single-requester burst against the credit cap.
        accepts = 0;
        repeat (6) begin
            step(1, 2'b01, 1, 0, 2'b00, 0, rdy);
            if (rdy[0]) accepts++;
        end
        check_eq("burst_grants", CW'(accepts), CW'(4));
        repeat (6) step(1, 2'b00, 1, 1, 2'b11, 0, rdy);

        // Contention with responses flowing.
        repeat (30) step(1, 2'b11, 1, 1'($urandom_range(0, 1)), 2'b11, 0, rdy);
        repeat (6) step(1, 2'b00, 1, 1, 2'b11, 0, rdy);

        // Backpressure then release.
        step(1, 2'b01, 0, 0, 2'b00, 0, rdy);
        repeat (3) step(1, 2'b10, 0, 0, 2'b00, 0, rdy);
        repeat (2) step(1, 2'b10, 1, 0, 2'b00, 0, rdy);
        repeat (6) step(1, 2'b00, 1, 1, 2'b11, 0, rdy);

        // Response stall for requester 1.
        step(1, 2'b10, 1, 0, 2'b00, 0, rdy);
        step(1, 2'b00, 1, 0, 2'b00, 0, rdy);
        repeat (3) step(1, 2'b00, 1, 1, 2'b00, 0, rdy);
        step(1, 2'b00, 1, 1, 2'b10, 0, rdy);

        // Flush with 3 in flight plus a valid slot.
        repeat (4) step(1, 2'b01, 1, 0, 2'b00, 0, rdy);
        step(1, 2'b00, 0, 0, 2'b00, 1, rdy);
        repeat (3) step(1, 2'b00, 1, 1, 2'b11, 0, rdy);
        step(1, 2'b01, 1, 0, 2'b00, 0, rdy);
        repeat (3) step(1, 2'b00, 1, 1, 2'b11, 0, rdy);

        // Reset mid-operation, then full credit must be available again.
        repeat (2) step(1, 2'b01, 1, 0, 2'b00, 0, rdy);
        step(0, 2'b01, 1, 1, 2'b11, 0, rdy);
        accepts = 0;
        repeat (5) begin
            step(1, 2'b01, 1, 0, 2'b00, 0, rdy);
            if (rdy[0]) accepts++;
        end
        check_eq("post_reset_grants", CW'(accepts), CW'(4));

        // Fully random traffic.
        repeat (600) begin
            step(($urandom_range(0, 199) != 0),
                 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 15) == 0),
                 rdy);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/bp_be_mmu_cmd_arbiter.md
Name: bp_be_mmu_cmd_arbiter

Overview:
- Shares the BE MMU command/response channel between two requesters: requester 0 is the pipeline memory stage, requester 1 is the microcode/auxiliary sequencer.
- Round-robin arbitration feeds a one-entry registered issue slot.
- A credit counter caps in-flight commands; an in-order ID FIFO routes each response back to its originator.
- A flush kills in-flight responses without stalling the MMU.

Parameters:
- cmd_width_p, 136, bp_be_mmu_cmd_width (fu_op + 64b eaddr + 64b data); opaque payload.
- resp_width_p, 72, bp_be_mmu_resp_width (64b data + exception); opaque payload.
- max_outstanding_p, 4, max commands held in issue slot plus in flight (power of 2, >=2).

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  synchronous reset, active-low
- cmd_v_i  in  2  per-requester command valid
- cmd0_i  in  cmd_width_p  requester 0 command
- cmd1_i  in  cmd_width_p  requester 1 command
- cmd_ready_o  out  2  per-requester accept; at most one bit high per cycle
- mmu_cmd_v_o  out  1  issue slot valid
- mmu_cmd_o  out  cmd_width_p  issue slot command
- mmu_cmd_ready_i  in  1  MMU accepts issue slot
- mmu_resp_v_i  in  1  MMU response valid (in order)
- mmu_resp_i  in  resp_width_p  MMU response
- mmu_resp_ready_o  out  1  arbiter accepts response
- resp_v_o  out  2  one-hot response valid, indexed by originator
- resp_o  out  resp_width_p  response payload (mmu_resp_i passthrough)
- resp_ready_i  in  2  requester response ready
- flush_i  in  1  kill all un-returned commands

Behaviour:
- Reset (reset_n_i=0 at posedge): slot empty, credit count 0, ID FIFO empty, kill bits 0, RR pointer to requester 0. Outputs during/after reset: mmu_cmd_v_o=0, cmd_ready_o=0, resp_v_o=0, mmu_resp_ready_o=0. Reset mid-transaction discards everything; late MMU responses after reset are a system error, not handled.
- Credit: count = slot occupancy + FIFO occupancy, range 0..max_outstanding_p.
- can_accept = ~flush_i & count_next_free & (slot empty | (mmu_cmd_v_o & mmu_cmd_ready_i)), where count_next_free means count < max_outstanding_p, or a response handshake/kill-drop occurs this cycle.
- Arbitration: if can_accept, grant the single requester with cmd_v_i. If both are valid, grant the one the RR pointer names; the pointer then flips to the other. The pointer updates only on grant. cmd_ready_o[g]=can_accept for the granted requester only, and is not gated by its own cmd_v_i.
- Accept latency: command granted in cycle N appears on mmu_cmd_o with mmu_cmd_v_o=1 in cycle N+1. The slot holds the command and its originator ID stable until mmu_cmd_ready_i.
- Issue handshake (mmu_cmd_v_o & mmu_cmd_ready_i): push {id, kill=0} into ID FIFO (depth max_outstanding_p; cannot overflow by credit). Simultaneous issue + new grant: slot reloads, no bubble.
- Response routing: when the FIFO is non-empty and the head is not killed, resp_v_o[head.id]=mmu_resp_v_i and mmu_resp_ready_o=resp_ready_i[head.id]. Pop and decrement credit on mmu_resp_v_i & mmu_resp_ready_o.
- Killed head: mmu_resp_ready_o=1, resp_v_o=0; the response is dropped, the FIFO pops and credit decrements.
- FIFO empty: mmu_resp_ready_o=0, resp_v_o=0.
- Flush (flush_i=1 in cycle N):
  - No grant in cycle N.
  - Slot cleared unless it handshakes in cycle N. If it does, the pushed entry is written with kill=1.
  - All existing FIFO entries get kill=1, except a head popping in the same cycle, which completes normally.
  - Credit is adjusted for the cleared slot.
  - New commands are accepted from N+1.
- Simultaneous pop + push with the FIFO full-to-credit: legal; the FIFO pointers wrap modulo max_outstanding_p.
- Credit increments on grant, decrements on pop or slot clear; simultaneous inc/dec nets to zero.

Test Plan:
- Single requester burst: cmd_v_i=01 for 6 cycles, mmu_cmd_ready_i=1, no responses -> exactly 4 grants; cmd_ready_o=00 once count=4; mmu_cmd_o order matches the input order.
- Contention: cmd_v_i=11 continuously, MMU always ready, responses returned 2 cycles later -> grants alternate 0,1,0,1. Each response appears on resp_v_o=01 or 10, matching the issuing order.
- Backpressure: mmu_cmd_ready_i=0 for 3 cycles with slot valid -> mmu_cmd_o stable and cmd_ready_o=00. On ready, the slot refills the same cycle, with no idle cycle.
- Response stall: resp_ready_i=00 with response pending for requester 1 -> mmu_resp_ready_o=0 and resp_v_o=10 held. Raising resp_ready_i[1] pops the entry and frees one credit the same cycle.
- Flush: 3 in flight + slot valid, flush_i pulse -> slot cleared and count=3. The next 3 MMU responses are consumed with resp_v_o=00. A new command issued after the flush returns its response normally.
- Reset mid-operation: reset_n_i=0 for 1 cycle with 2 in flight -> all outputs 0 and count=0. The bench requires 4 fresh accepts to be possible afterward.
